// File: rtl/shift_operand_unit.sv
// shift_operand_unit
//   Operand-2 front end for the ARM data-processing datapath. Decodes the
//   12-bit operand-2 field into one of three forms and produces the final
//   32-bit operand plus the shifter carry-out behind a valid/ready handshake:
//     IMM    : i_bit = 1             imm8 ROR (2*rot)               1-cycle latency
//     REGIMM : i_bit = 0, f[4] = 0   Rm shifted by imm5 (f[11:7])   1-cycle latency
//     REGREG : i_bit = 0, f[4] = 1   Rm shifted by Rs[AMT_W-1:0]    2-cycle latency
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. While
// out_valid is high and out_ready is low, op2/shifter_carry hold stable.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready, i_bit, op2_field[11:0], rm_data, rs_data, carry_in
//   out_valid/out_ready, op2[31:0], shifter_carry, perf_count[PERF_W-1:0]
//
// Optional build macro SHIFT_OPERAND_PERF_EN: when defined, perf_count counts
// completed output transfers (wrapping); when undefined it is tied to 0.

module shift_operand_unit #(
   parameter int AMT_W  = 8,
   parameter int PERF_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              i_bit,
   input  logic [11:0]       op2_field,
   input  logic [31:0]       rm_data,
   input  logic [31:0]       rs_data,
   input  logic              carry_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       op2,
   output logic              shifter_carry,
   output logic [PERF_W-1:0] perf_count
);

   typedef enum logic [1:0] {S_EMPTY, S_AMT, S_FULL} state_t;

   state_t             state_q, state_d;
   logic [31:0]        op2_q, op2_d;
   logic               carry_q, carry_d;
   logic [31:0]        lat_rm_q, lat_rm_d;
   logic               lat_c_q, lat_c_d;
   logic [1:0]         lat_sh_q, lat_sh_d;
   logic [AMT_W-1:0]   lat_amt_q, lat_amt_d;

   // Register-style shift with a (possibly large) amount; returns {result, carry}.
   // All real shifting happens on 64-bit intermediates, so no 32-bit value is
   // ever shifted by its full width.
   function automatic logic [32:0] shift_core(input logic [31:0] rm, input logic c,
                                              input logic [1:0] sh, input logic [63:0] a);
      logic [63:0] t;
      logic [31:0] res;
      logic        co;
      t   = '0;
      res = rm;
      co  = c;
      if (a != 64'd0) begin
         case (sh)
            2'b00: begin
               if (a < 64'd32) begin
                  t = {32'b0, rm} << a[4:0];
                  res = t[31:0];
                  co  = t[32];
               end else begin
                  res = '0;
                  co  = (a == 64'd32) ? rm[0] : 1'b0;
               end
            end
            2'b01: begin
               if (a < 64'd32) begin
                  t = {rm, 32'b0} >> a[4:0];
                  res = t[63:32];
                  co  = t[31];
               end else begin
                  res = '0;
                  co  = (a == 64'd32) ? rm[31] : 1'b0;
               end
            end
            2'b10: begin
               if (a < 64'd32) begin
                  t = $signed({rm, 32'b0}) >>> a[4:0];
                  res = t[63:32];
                  co  = t[31];
               end else begin
                  res = {32{rm[31]}};
                  co  = rm[31];
               end
            end
            default: begin
               // ROR by a multiple of 32 leaves Rm intact but still reports bit 31.
               if (a[4:0] == 5'd0) begin
                  res = rm;
                  co  = rm[31];
               end else begin
                  t = {rm, rm} >> a[4:0];
                  res = t[31:0];
                  co  = t[31];
               end
            end
         endcase
      end
      return {res, co};
   endfunction

   // Result for the single-cycle forms (IMM, REGIMM), from live inputs.
   logic [32:0] fast_res;
   always_comb begin
      logic [63:0] t;
      logic [4:0]  s;
      t = '0;
      s = op2_field[11:7];
      if (i_bit) begin
         t = {24'b0, op2_field[7:0], 24'b0, op2_field[7:0]} >> {op2_field[11:8], 1'b0};
         fast_res = {t[31:0], (op2_field[11:8] == 4'd0) ? carry_in : t[31]};
      end else if (s == 5'd0) begin
         // Zero immediate amount encodes LSL #0, LSR #32, ASR #32 and RRX.
         case (op2_field[6:5])
            2'b00:   fast_res = {rm_data, carry_in};
            2'b01:   fast_res = {32'b0, rm_data[31]};
            2'b10:   fast_res = {{32{rm_data[31]}}, rm_data[31]};
            default: fast_res = {carry_in, rm_data[31:1], rm_data[0]};
         endcase
      end else begin
         fast_res = shift_core(rm_data, carry_in, op2_field[6:5], 64'(s));
      end
   end

   // Second cycle of REGREG, from the latched request.
   logic [32:0] slow_res;
   always_comb slow_res = shift_core(lat_rm_q, lat_c_q, lat_sh_q, 64'(lat_amt_q));

   logic is_regreg;
   assign is_regreg = !i_bit && op2_field[4];

   assign out_valid     = (state_q == S_FULL);
   assign in_ready      = (state_q == S_EMPTY) || ((state_q == S_FULL) && out_ready);
   assign op2           = op2_q;
   assign shifter_carry = carry_q;

   always_comb begin
      state_d   = state_q;
      op2_d     = op2_q;
      carry_d   = carry_q;
      lat_rm_d  = lat_rm_q;
      lat_c_d   = lat_c_q;
      lat_sh_d  = lat_sh_q;
      lat_amt_d = lat_amt_q;
      if (state_q == S_AMT) begin
         {op2_d, carry_d} = slow_res;
         state_d          = S_FULL;
      end else if (state_q == S_FULL && out_ready && !in_valid) begin
         state_d = S_EMPTY;
      end
      // in_ready already covers both EMPTY and the FULL back-to-back case.
      if (in_valid && in_ready) begin
         if (is_regreg) begin
            lat_rm_d  = rm_data;
            lat_c_d   = carry_in;
            lat_sh_d  = op2_field[6:5];
            lat_amt_d = rs_data[AMT_W-1:0];
            state_d   = S_AMT;
         end else begin
            {op2_d, carry_d} = fast_res;
            state_d          = S_FULL;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_EMPTY;
         op2_q     <= '0;
         carry_q   <= 1'b0;
         lat_rm_q  <= '0;
         lat_c_q   <= 1'b0;
         lat_sh_q  <= '0;
         lat_amt_q <= '0;
      end else begin
         state_q   <= state_d;
         op2_q     <= op2_d;
         carry_q   <= carry_d;
         lat_rm_q  <= lat_rm_d;
         lat_c_q   <= lat_c_d;
         lat_sh_q  <= lat_sh_d;
         lat_amt_q <= lat_amt_d;
      end
   end

`ifdef SHIFT_OPERAND_PERF_EN
   logic [PERF_W-1:0] perf_q, perf_d;
   always_comb perf_d = perf_q + PERF_W'(out_valid && out_ready);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) perf_q <= '0;
      else        perf_q <= perf_d;
   end
   assign perf_count = perf_q;
`else
   assign perf_count = '0;
`endif

   // Only the low AMT_W bits of Rs form the shift amount.
   generate
      if (AMT_W < 32) begin : g_rs_hi
         logic unused_rs_hi;
         assign unused_rs_hi = ^rs_data[31:AMT_W];
      end
   endgenerate

endmodule

// File: doc/shift_operand_unit.md
Name: shift_operand_unit

Overview:
- Operand-2 front end for the ARM data-processing datapath.
- Sits upstream of the ALU, beside the 4-way combinational shifter.
- Decodes the 12-bit operand-2 field: rotated imm8, register shifted by imm5, or register shifted by Rs[7:0].
- Produces the final 32-bit operand and the shifter carry-out, using full ARM special-case semantics, behind a valid/ready handshake.

Parameters:
AMT_W, 8, number of low Rs bits used as the register-specified shift amount (ARM: 8)
PERF_W, 16, width of the optional transfer counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
i_bit  in  1  instr[25]; 1 = immediate operand
op2_field  in  12  instr[11:0]
rm_data  in  32  Rm value
rs_data  in  32  Rs value (register-specified form only)
carry_in  in  1  current CPSR C flag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
op2  out  32  shifted or rotated operand
shifter_carry  out  1  shifter carry-out
perf_count  out  PERF_W  completed transfers (see Optional Feature)

Behaviour:
- Forms, decoded from i_bit and op2_field:
  - IMM: i_bit = 1.
  - REGIMM: i_bit = 0, op2_field[4] = 0.
  - REGREG: i_bit = 0, op2_field[4] = 1.
- Shift type sh = op2_field[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- State machine, states EMPTY, AMT, FULL:
  - EMPTY: in_ready = 1. On in_valid, IMM and REGIMM compute their result and go to FULL (1-cycle latency). REGREG latches rm_data, carry_in, sh and amt = rs_data[AMT_W-1:0], then goes to AMT.
  - AMT: in_ready = 0. Computes the result from the latched values, then goes to FULL (2-cycle latency).
  - FULL: out_valid = 1.
    - On out_ready with no new request: go to EMPTY.
    - On out_ready and in_valid in the same cycle: in_ready = 1, the new request is accepted, and the next state follows the EMPTY rules (back-to-back, no bubble for IMM/REGIMM).
    - Without out_ready: op2 and shifter_carry hold stable and in_ready = 0.
- All inputs are sampled only on the accepting edge. rs_data/rm_data may change afterwards.
- IMM: op2 = imm8 ROR (2*rot), where imm8 = op2_field[7:0] and rot = op2_field[11:8].
  - shifter_carry = carry_in if rot = 0, else op2[31].
- REGIMM, amount s = op2_field[11:7]:
  - LSL, s = 0: op2 = Rm, carry = C. Otherwise standard LSL, carry = last bit shifted out.
  - LSR, s = 0: means LSR #32. op2 = 0, carry = Rm[31].
  - ASR, s = 0: means ASR #32. op2 = {32{Rm[31]}}, carry = Rm[31].
  - ROR, s = 0: means RRX. op2 = {C, Rm[31:1]}, carry = Rm[0].
- REGREG, amount a:
  - a = 0, any type: op2 = Rm, carry = C.
  - LSL: a = 32 gives 0 with carry Rm[0]. a > 32 gives 0 with carry 0.
  - LSR: a = 32 gives 0 with carry Rm[31]. a > 32 gives 0 with carry 0.
  - ASR: a ≥ 32 gives sign fill with carry Rm[31].
  - ROR: if a[4:0] = 0 and a ≠ 0, op2 = Rm with carry Rm[31]. Otherwise rotate by a[4:0].
  - 1 ≤ a ≤ 31: standard shift, carry = last bit shifted out.
- Width rules:
  - All shift arithmetic uses 64-bit or explicitly masked intermediates.
  - No expression may shift by 32 − 0 on a 32-bit value.
- Reset (asynchronous, any state including AMT mid-operation):
  - state = EMPTY, out_valid = 0, op2 = 0, shifter_carry = 0, perf_count = 0.
  - in_ready = 1 combinationally once reset is released.
  - The in-flight request is dropped.

Optional Feature:
- Macro: SHIFT_OPERAND_PERF_EN.
- Defined: perf_count increments by 1 on each out_valid & out_ready cycle. It wraps modulo 2^PERF_W and is cleared by reset.
- Undefined: the counter register is not built and perf_count is tied to 0. Port list is unchanged.

Test Plan:
- IMM, op2_field = 0x4FF (rot = 4, imm = 0xFF), C = 0 → after 1 cycle: op2 = 0xFF000000, carry = 1. op2_field = 0x0AB, C = 1 → op2 = 0x000000AB, carry = 1.
- REGIMM specials, Rm = 0x80000001, C = 1:
  - LSR #0 → 0x00000000, carry 1.
  - ASR #0 → 0xFFFFFFFF, carry 1.
  - RRX → 0xC0000000, carry 1.
  - LSL #0 → 0x80000001, carry 1.
- REGREG, Rm = 0x00000001:
  - LSL, Rs = 32 → op2 0, carry 1.
  - LSL, Rs = 33 → op2 0, carry 0.
  - Rs = 0x100 (a = 0) → op2 = 0x00000001, carry = C.
  - ROR, Rs = 64 → op2 = 0x00000001, carry 0.
  - Each result arrives exactly 2 cycles after acceptance, with in_ready = 0 during AMT.
- Backpressure: hold out_ready = 0 for 5 cycles in FULL → op2 stable, in_ready = 0. Raise out_ready together with a new IMM request → accepted in the same cycle, next result valid on the following cycle.
- Reset asserted while in AMT → out_valid = 0, op2 = 0 immediately (asynchronous). After release, in_ready = 1 and the aborted request never appears at the output.
- With SHIFT_OPERAND_PERF_EN: 3 completed transfers → perf_count = 3. PERF_W = 2 with 5 transfers → perf_count = 1. Without the macro → perf_count = 0 throughout.
